// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch path.
package rv32_fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush and occupancy count.
// Storage is reset so the head reads as zero straight out of reset.
module fetch_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer and occupancy update; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; a write is suppressed when the same cycle flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word-aligned fetches under a
// credit limit, buffers in-order responses and hands them to decode.
// A redirect flushes the buffer and drops responses still in flight.
module instr_fetch_unit
    import rv32_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     QDEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int unsigned CNT_W   = $clog2(QDEPTH) + 1;
    localparam int unsigned SUM_W   = CNT_W + 1;
    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] queue_count;
    logic [SUM_W-1:0] credit_used;
    logic [XLEN-1:0]  resp_pc;
    logic             req_fire;
    logic             resp_drop;
    logic             resp_keep;
    logic             deq_fire;
    fetch_entry_t     enq_entry;
    fetch_entry_t     head_entry;

    // Handshake qualification; requests and decode valid are held off during a redirect.
    always_comb begin
        credit_used    = SUM_W'(outstanding) + SUM_W'(queue_count);
        imem_req_valid = !rst && !redirect_valid && (credit_used < SUM_W'(QDEPTH));
        inst_valid     = !redirect_valid && (queue_count != '0);
        req_fire       = imem_req_valid && imem_req_ready;
        resp_drop      = imem_resp_valid && (redirect_valid || (drop_cnt_q != '0));
        resp_keep      = imem_resp_valid && !resp_drop;
        deq_fire       = inst_valid && inst_ready;
        enq_entry.pc    = resp_pc;
        enq_entry.instr = imem_resp_data;
    end

    // Next PC and count of stale responses still to be discarded.
    always_comb begin
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            pc_d       = align_pc(redirect_pc);
            drop_cnt_d = outstanding - CNT_W'(imem_resp_valid);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + PC_STEP;
            end
            if (imem_resp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
        end
    end

    // PC and drop counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Addresses of accepted requests, popped by every response; its depth is the outstanding count.
    fetch_queue #(
        .WIDTH (XLEN),
        .DEPTH (QDEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (1'b0),
        .push_i      (req_fire),
        .push_data_i (pc_q),
        .pop_i       (imem_resp_valid),
        .head_o      (resp_pc),
        .count_o     (outstanding)
    );

    // Fetched instructions waiting for decode; flushed on redirect.
    fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_inst_queue (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (resp_keep),
        .push_data_i (enq_entry),
        .pop_i       (deq_fire),
        .head_o      (head_entry),
        .count_o     (queue_count)
    );

    assign imem_req_addr = pc_q;
    assign inst_data     = head_entry.instr;
    assign inst_pc       = head_entry.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised bench for instr_fetch_unit: an in-order memory model with
// variable latency answers requests, and the decode stream is checked
// against the architectural PC sequence (consecutive words from the last
// reset or redirect target).
module tb_instr_fetch_unit;

    localparam int unsigned QDEPTH   = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rel_cyc = -1;
    int n_acc = 0;
    int n_deliv = 0;
    int total_deliv = 0;
    int first_valid_cyc = -1;
    int first_deliv_cyc = -1;
    int lat_min = 1;
    int lat_max = 1;

    logic        drv_rst = 1'b1;
    logic        drv_req_ready = 1'b0;
    logic        drv_inst_ready = 1'b0;
    logic        drv_redirect = 1'b0;
    logic [31:0] drv_redirect_pc = '0;

    logic [31:0] mem_addr_q [$];
    int          mem_due_q [$];

    logic [31:0] exp_req_pc = RESET_PC;
    logic [31:0] exp_inst_pc = RESET_PC;
    logic        stall_prev = 1'b0;
    logic [31:0] stall_pc = '0;
    logic        last_inst_valid = 1'b0;
    logic        last_req_valid = 1'b0;
    logic        got_first = 1'b0;
    logic [31:0] first_deliv_pc = '0;
    logic        got_first_acc = 1'b0;
    logic [31:0] first_acc_addr = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs on the falling edge, then observe and update the model.
    task automatic cycle_step();
        @(negedge clk);
        rst            = drv_rst;
        imem_req_ready = drv_req_ready;
        inst_ready     = drv_inst_ready;
        redirect_valid = drv_redirect && !drv_rst;
        redirect_pc    = drv_redirect_pc;
        if (drv_rst) begin
            mem_addr_q.delete();
            mem_due_q.delete();
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end else if (mem_due_q.size() != 0 && mem_due_q[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_addr_q[0] ^ KEY;
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom();
        end
        #1;
        if (rst) begin
            check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
            check_eq("rst_req_addr", imem_req_addr, RESET_PC);
            check_eq("rst_inst_data", inst_data, 32'd0);
            check_eq("rst_inst_pc", inst_pc, 32'd0);
            exp_req_pc  = RESET_PC;
            exp_inst_pc = RESET_PC;
            rel_cyc     = -1;
            stall_prev  = 1'b0;
        end else begin
            rel_cyc++;
            if (redirect_valid) begin
                check_eq("redir_req_valid", 32'(imem_req_valid), 32'd0);
                check_eq("redir_inst_valid", 32'(inst_valid), 32'd0);
                exp_req_pc  = redirect_pc & 32'hFFFF_FFFC;
                exp_inst_pc = redirect_pc & 32'hFFFF_FFFC;
                stall_prev  = 1'b0;
            end else begin
                if (stall_prev) begin
                    check_eq("stall_valid", 32'(inst_valid), 32'd1);
                    check_eq("stall_pc", inst_pc, stall_pc);
                end
                if (inst_valid && first_valid_cyc < 0) first_valid_cyc = rel_cyc;
                if (imem_req_valid && imem_req_ready) begin
                    check_eq("req_addr", imem_req_addr, exp_req_pc);
                    mem_addr_q.push_back(imem_req_addr);
                    mem_due_q.push_back(cyc + $urandom_range(lat_min, lat_max));
                    check_eq("credit_bound", 32'(mem_addr_q.size() <= int'(QDEPTH)), 32'd1);
                    if (!got_first_acc) begin
                        got_first_acc  = 1'b1;
                        first_acc_addr = imem_req_addr;
                    end
                    exp_req_pc = exp_req_pc + 32'd4;
                    n_acc++;
                end
                if (inst_valid && inst_ready) begin
                    check_eq("inst_pc", inst_pc, exp_inst_pc);
                    check_eq("inst_data", inst_data, exp_inst_pc ^ KEY);
                    if (!got_first) begin
                        got_first       = 1'b1;
                        first_deliv_pc  = inst_pc;
                        first_deliv_cyc = rel_cyc;
                    end
                    exp_inst_pc = exp_inst_pc + 32'd4;
                    n_deliv++;
                    total_deliv++;
                end
                stall_prev = inst_valid && !inst_ready;
                stall_pc   = inst_pc;
            end
        end
        last_inst_valid = inst_valid;
        last_req_valid  = imem_req_valid;
        cyc++;
    endtask

    task automatic clear_marks();
        n_acc = 0;
        n_deliv = 0;
        first_valid_cyc = -1;
        first_deliv_cyc = -1;
        got_first = 1'b0;
        got_first_acc = 1'b0;
    endtask

    task automatic do_reset(input int n);
        drv_rst = 1'b1;
        drv_redirect = 1'b0;
        repeat (n) cycle_step();
        drv_rst = 1'b0;
        clear_marks();
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        drv_redirect = 1'b1;
        drv_redirect_pc = target;
        cycle_step();
        drv_redirect = 1'b0;
        clear_marks();
    endtask

    initial begin
        // Streaming with 1-cycle memory: first decode valid two cycles after release.
        do_reset(2);
        lat_min = 1; lat_max = 1;
        drv_req_ready = 1'b1; drv_inst_ready = 1'b1;
        repeat (20) cycle_step();
        check_eq("first_valid_cycle", 32'(first_valid_cyc), 32'd2);
        check_eq("stream_count", 32'(n_deliv), 32'd18);

        // Decode stalled: credit stops issue at four, then drain and resume.
        do_reset(1);
        drv_inst_ready = 1'b0;
        repeat (12) cycle_step();
        check_eq("fill_accepts", 32'(n_acc), 32'd4);
        check_eq("fill_req_valid", 32'(last_req_valid), 32'd0);
        check_eq("fill_inst_valid", 32'(last_inst_valid), 32'd1);
        n_deliv = 0;
        drv_inst_ready = 1'b1;
        repeat (10) cycle_step();
        check_eq("drain_count", 32'(n_deliv), 32'd10);

        // 3-cycle memory, redirect with two requests in flight.
        do_reset(1);
        lat_min = 3; lat_max = 3;
        repeat (2) cycle_step();
        drv_req_ready = 1'b0;
        pulse_redirect(32'h0000_0103);
        drv_req_ready = 1'b1;
        repeat (14) cycle_step();
        check_eq("redir_first_req", first_acc_addr, 32'h0000_0100);
        check_eq("redir_first_pc", first_deliv_pc, 32'h0000_0100);
        check_eq("redir_first_cycle", 32'(first_deliv_cyc), 32'd7);

        // Redirect coinciding with a response and a decode handshake.
        do_reset(1);
        lat_min = 1; lat_max = 1;
        repeat (6) cycle_step();
        check_eq("pre_redir_valid", 32'(last_inst_valid), 32'd1);
        pulse_redirect(32'h0000_2000);
        cycle_step();
        check_eq("post_redir_empty", 32'(last_inst_valid), 32'd0);
        repeat (8) cycle_step();
        check_eq("r2_first_pc", first_deliv_pc, 32'h0000_2000);
        check_eq("r2_first_cycle", 32'(first_deliv_cyc), 32'd9);

        // Address wrap through the top of memory.
        pulse_redirect(32'hFFFF_FFF8);
        repeat (8) cycle_step();
        check_eq("wrap_first_pc", first_deliv_pc, 32'hFFFF_FFF8);
        check_eq("wrap_count", 32'(n_deliv), 32'd6);

        // Reset with the queue full, then restart from the reset PC.
        drv_inst_ready = 1'b0;
        repeat (10) cycle_step();
        check_eq("full_req_valid", 32'(last_req_valid), 32'd0);
        do_reset(1);
        drv_inst_ready = 1'b1;
        repeat (12) cycle_step();
        check_eq("restart_first_cycle", 32'(first_valid_cyc), 32'd2);
        check_eq("restart_first_pc", first_deliv_pc, RESET_PC);

        // Random traffic: variable latency, backpressure on both sides, redirects.
        total_deliv = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) begin
                lat_min = 1;
                lat_max = $urandom_range(1, 4);
            end
            if ($urandom_range(0, 799) == 0) begin
                do_reset(1);
            end else begin
                drv_req_ready   = ($urandom_range(0, 3) != 0);
                drv_inst_ready  = ($urandom_range(0, 2) != 0);
                drv_redirect    = ($urandom_range(0, 39) == 0);
                drv_redirect_pc = $urandom();
                cycle_step();
            end
        end
        check_eq("random_progress", 32'(total_deliv > 300), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
